mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller that arbitrates instruction fetches and MEM-stage
// loads/stores onto a byte-wide RAM. Define MEM_CTRL_FETCH_BUF_EN for a one-entry fetch buffer.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_done_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_len_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_done_o,
  output logic        stall_if_o,
  output logic        stall_mem_o,
  output logic [31:0] ram_addr_o,
  output logic [7:0]  ram_dout_o,
  output logic        ram_wr_o,
  input  logic [7:0]  ram_din_i
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IF_RD  = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic logic [7:0] f_byte(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] f_ins(input logic [31:0] w, input logic [1:0] i,
                                        input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (i)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  // Index of the final byte; size code 11 behaves as a full word.
  function automatic logic [1:0] f_len_last(input logic [1:0] len);
    logic [1:0] l;
    case (len)
      2'b00:   l = 2'd0;
      2'b01:   l = 2'd1;
      default: l = 2'd3;
    endcase
    return l;
  endfunction

  state_t      r_state, w_state_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic [1:0]  r_last, w_last_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_rbuf, w_rbuf_nxt;
  logic [31:0] r_ram_addr, w_ram_addr_nxt;
  logic [7:0]  r_ram_dout, w_ram_dout_nxt;
  logic        r_ram_wr, w_ram_wr_nxt;
  logic        r_if_done, w_if_done_nxt;
  logic        r_mem_done, w_mem_done_nxt;
  logic [31:0] r_if_data, w_if_data_nxt;
  logic [31:0] r_mem_rdata, w_mem_rdata_nxt;

  logic [1:0]  w_cnt_inc;
  logic [31:0] w_addr_inc;
  logic [31:0] w_rbuf_upd;
  logic        w_at_last;

`ifdef MEM_CTRL_FETCH_BUF_EN
  logic        r_buf_vld, w_buf_vld_nxt;
  logic [31:0] r_buf_tag, w_buf_tag_nxt;
  logic [31:0] r_buf_word, w_buf_word_nxt;
  logic        w_buf_hit;
  assign w_buf_hit = r_buf_vld && (r_buf_tag == if_addr_i);
`endif

  assign w_cnt_inc  = r_cnt + 2'd1;
  assign w_addr_inc = r_addr + {30'd0, w_cnt_inc};
  assign w_rbuf_upd = f_ins(r_rbuf, r_cnt, ram_din_i);
  assign w_at_last  = (r_cnt == r_last);

  assign if_data_o   = r_if_data;
  assign if_done_o   = r_if_done;
  assign mem_rdata_o = r_mem_rdata;
  assign mem_done_o  = r_mem_done;
  assign ram_addr_o  = r_ram_addr;
  assign ram_dout_o  = r_ram_dout;
  assign ram_wr_o    = r_ram_wr;
  assign stall_if_o  = if_req_i & ~r_if_done;
  assign stall_mem_o = mem_req_i & ~r_mem_done;

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_last_nxt      = r_last;
    w_cnt_nxt       = r_cnt;
    w_rbuf_nxt      = r_rbuf;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_dout_nxt  = 8'h00;
    w_ram_wr_nxt    = 1'b0;
    w_if_done_nxt   = 1'b0;
    w_mem_done_nxt  = 1'b0;
    w_if_data_nxt   = r_if_data;
    w_mem_rdata_nxt = r_mem_rdata;
`ifdef MEM_CTRL_FETCH_BUF_EN
    w_buf_vld_nxt   = r_buf_vld;
    w_buf_tag_nxt   = r_buf_tag;
    w_buf_word_nxt  = r_buf_word;
`endif
    case (r_state)
      ST_IDLE: begin
        if (mem_req_i) begin
          w_addr_nxt     = mem_addr_i;
          w_wdata_nxt    = mem_wdata_i;
          w_last_nxt     = f_len_last(mem_len_i);
          w_cnt_nxt      = 2'd0;
          w_rbuf_nxt     = 32'h0000_0000;
          w_ram_addr_nxt = mem_addr_i;
          if (mem_we_i) begin
            w_state_nxt    = ST_MEM_WR;
            w_ram_wr_nxt   = 1'b1;
            w_ram_dout_nxt = mem_wdata_i[7:0];
`ifdef MEM_CTRL_FETCH_BUF_EN
            // A store may alias the buffered instruction word.
            w_buf_vld_nxt  = 1'b0;
`endif
          end else begin
            w_state_nxt = ST_MEM_RD;
          end
        end else if (if_req_i) begin
`ifdef MEM_CTRL_FETCH_BUF_EN
          if (w_buf_hit) begin
            w_state_nxt   = ST_DONE;
            w_if_done_nxt = 1'b1;
            w_if_data_nxt = r_buf_word;
          end else begin
            w_state_nxt    = ST_IF_RD;
            w_addr_nxt     = if_addr_i;
            w_last_nxt     = 2'd3;
            w_cnt_nxt      = 2'd0;
            w_rbuf_nxt     = 32'h0000_0000;
            w_ram_addr_nxt = if_addr_i;
          end
`else
          w_state_nxt    = ST_IF_RD;
          w_addr_nxt     = if_addr_i;
          w_last_nxt     = 2'd3;
          w_cnt_nxt      = 2'd0;
          w_rbuf_nxt     = 32'h0000_0000;
          w_ram_addr_nxt = if_addr_i;
`endif
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IF_RD, ST_MEM_RD: begin
        w_rbuf_nxt = w_rbuf_upd;
        if (w_at_last) begin
          w_state_nxt = ST_DONE;
          if (r_state == ST_IF_RD) begin
            w_if_done_nxt  = 1'b1;
            w_if_data_nxt  = w_rbuf_upd;
`ifdef MEM_CTRL_FETCH_BUF_EN
            w_buf_vld_nxt  = 1'b1;
            w_buf_tag_nxt  = r_addr;
            w_buf_word_nxt = w_rbuf_upd;
`endif
          end else begin
            w_mem_done_nxt  = 1'b1;
            w_mem_rdata_nxt = w_rbuf_upd;
          end
        end else begin
          w_cnt_nxt      = w_cnt_inc;
          w_ram_addr_nxt = w_addr_inc;
        end
      end
      ST_MEM_WR: begin
        if (w_at_last) begin
          w_state_nxt    = ST_DONE;
          w_mem_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt      = w_cnt_inc;
          w_ram_addr_nxt = w_addr_inc;
          w_ram_wr_nxt   = 1'b1;
          w_ram_dout_nxt = f_byte(r_wdata, w_cnt_inc);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= 32'h0000_0000;
      r_wdata     <= 32'h0000_0000;
      r_last      <= 2'd0;
      r_cnt       <= 2'd0;
      r_rbuf      <= 32'h0000_0000;
      r_ram_addr  <= 32'h0000_0000;
      r_ram_dout  <= 8'h00;
      r_ram_wr    <= 1'b0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_data   <= 32'h0000_0000;
      r_mem_rdata <= 32'h0000_0000;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_last      <= w_last_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rbuf      <= w_rbuf_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_dout  <= w_ram_dout_nxt;
      r_ram_wr    <= w_ram_wr_nxt;
      r_if_done   <= w_if_done_nxt;
      r_mem_done  <= w_mem_done_nxt;
      r_if_data   <= w_if_data_nxt;
      r_mem_rdata <= w_mem_rdata_nxt;
    end
  end

`ifdef MEM_CTRL_FETCH_BUF_EN
  // Fetch buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_vld  <= 1'b0;
      r_buf_tag  <= 32'h0000_0000;
      r_buf_word <= 32'h0000_0000;
    end else begin
      r_buf_vld  <= w_buf_vld_nxt;
      r_buf_tag  <= w_buf_tag_nxt;
      r_buf_word <= w_buf_word_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a 4 KiB byte RAM model, expected load/fetch
// results queued at stimulus time and compared when the done pulses appear.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_done_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_len_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_done_o;
  logic        stall_if_o;
  logic        stall_mem_o;
  logic [31:0] ram_addr_o;
  logic [7:0]  ram_dout_o;
  logic        ram_wr_o;
  logic [7:0]  ram_din_i;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0]  ram [0:4095];
  logic        ram_loaded = 1'b0;
  logic [31:0] q_if[$];
  logic [32:0] q_mem[$];
  logic [31:0] wlog_a[$];
  logic [7:0]  wlog_d[$];

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
    .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o),
    .ram_addr_o(ram_addr_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o), .ram_din_i(ram_din_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_din_i = ram[ram_addr_o[11:0]];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h exp=%08h @%0t", tag, got, exp, $time);
    end
  endtask

  // RAM model: preload on the first edge, then record every write.
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
      ram[12'h100] <= 8'h13; ram[12'h101] <= 8'h05; ram[12'h102] <= 8'h00; ram[12'h103] <= 8'h00;
      ram[12'h104] <= 8'h37; ram[12'h105] <= 8'h01; ram[12'h106] <= 8'h00; ram[12'h107] <= 8'h80;
      ram[12'h020] <= 8'hAB;
      ram[12'h040] <= 8'h11; ram[12'h041] <= 8'h22; ram[12'h042] <= 8'h33; ram[12'h043] <= 8'h44;
      ram[12'h044] <= 8'h55;
      ram[12'h300] <= 8'hDE; ram[12'h301] <= 8'hAD; ram[12'h302] <= 8'hBE; ram[12'h303] <= 8'hEF;
      ram[12'hFFE] <= 8'h01; ram[12'hFFF] <= 8'h02; ram[12'h000] <= 8'h03; ram[12'h001] <= 8'h04;
      ram[12'h200] <= 8'h78; ram[12'h201] <= 8'h56; ram[12'h202] <= 8'h34; ram[12'h203] <= 8'h12;
      ram_loaded <= 1'b1;
    end else if (ram_wr_o) begin
      ram[ram_addr_o[11:0]] <= ram_dout_o;
      wlog_a.push_back(ram_addr_o);
      wlog_d.push_back(ram_dout_o);
    end
  end

  // Scoreboard: pop and compare on each done pulse.
  always @(posedge clk) begin
    logic [32:0] e;
    #1;
    if (if_done_o) begin
      if (q_if.size() == 0) check_val("if_unexpected_done", 32'd1, 32'd0);
      else check_val("if_data", if_data_o, q_if.pop_front());
    end
    if (mem_done_o) begin
      if (q_mem.size() == 0) check_val("mem_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q_mem.pop_front();
        if (e[32]) check_val("mem_rdata", mem_rdata_o, e[31:0]);
      end
    end
  end

  task automatic run_fetch(input logic [31:0] a, input logic [31:0] exp_d, input int exp_edges);
    int k;
    logic got;
    logic [31:0] prev;
    @(negedge clk);
    prev = ram_addr_o;
    if_req_i = 1'b1;
    if_addr_i = a;
    q_if.push_back(exp_d);
    k = 0;
    got = 1'b0;
    while (!got && k < 30) begin
      @(posedge clk); #1;
      k++;
      if (if_done_o) got = 1'b1;
      else begin
        check_val("fetch_stall", {31'd0, stall_if_o}, 32'd1);
        if (k <= 4) check_val("fetch_addr", ram_addr_o, a + 32'(k - 1));
      end
    end
    check_val("fetch_timeout", {31'd0, got}, 32'd1);
    check_val("fetch_latency", 32'(k), 32'(exp_edges));
    check_val("fetch_stall_done", {31'd0, stall_if_o}, 32'd0);
    if (exp_edges == 1) check_val("hit_addr_hold", ram_addr_o, prev);
    else check_val("fetch_addr_hold", ram_addr_o, a + 32'd3);
    @(negedge clk);
    if_req_i = 1'b0;
  endtask

  task automatic run_mem(input logic we, input logic [1:0] len, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_d);
    int k;
    int nb;
    logic got;
    nb = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    @(negedge clk);
    mem_req_i = 1'b1;
    mem_we_i = we;
    mem_len_i = len;
    mem_addr_i = a;
    mem_wdata_i = wd;
    q_mem.push_back({~we, exp_d});
    k = 0;
    got = 1'b0;
    while (!got && k < 30) begin
      @(posedge clk); #1;
      k++;
      if (mem_done_o) got = 1'b1;
      else begin
        check_val("mem_stall", {31'd0, stall_mem_o}, 32'd1);
        if (k <= nb) begin
          check_val("mem_addr", ram_addr_o, a + 32'(k - 1));
          check_val("mem_wr", {31'd0, ram_wr_o}, {31'd0, we});
        end
      end
    end
    check_val("mem_timeout", {31'd0, got}, 32'd1);
    check_val("mem_latency", 32'(k), 32'(nb + 1));
    check_val("mem_wr_idle", {31'd0, ram_wr_o}, 32'd0);
    check_val("mem_dout_idle", {24'd0, ram_dout_o}, 32'd0);
    @(negedge clk);
    mem_req_i = 1'b0;
    mem_we_i = 1'b0;
  endtask

  initial begin
    int k;
    logic got;
    rst = 1'b0;
    if_req_i = 1'b0; if_addr_i = 32'h0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_len_i = 2'b00; mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ram_addr", ram_addr_o, 32'h0);
    check_val("rst_ram_wr", {31'd0, ram_wr_o}, 32'd0);
    check_val("rst_ram_dout", {24'd0, ram_dout_o}, 32'd0);
    check_val("rst_dones", {30'd0, if_done_o, mem_done_o}, 32'd0);
    check_val("rst_if_data", if_data_o, 32'h0);
    check_val("rst_mem_rdata", mem_rdata_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    run_fetch(32'h0000_0100, 32'h0000_0513, 5);

    // Simultaneous requests: load wins, fetch follows after DONE.
    @(negedge clk);
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'b00; mem_addr_i = 32'h20;
    if_req_i = 1'b1; if_addr_i = 32'h104;
    q_mem.push_back({1'b1, 32'h0000_00AB});
    q_if.push_back(32'h8000_0137);
    k = 0; got = 1'b0;
    while (!got && k < 30) begin
      @(posedge clk); #1;
      k++;
      if (mem_done_o) begin
        check_val("arb_mem_latency", 32'(k), 32'd2);
        check_val("arb_if_not_done", {31'd0, if_done_o}, 32'd0);
        mem_req_i = 1'b0;
      end
      if (if_done_o) got = 1'b1;
      else check_val("arb_stall_if", {31'd0, stall_if_o}, 32'd1);
    end
    check_val("arb_if_latency", 32'(k), 32'd8);
    @(negedge clk);
    if_req_i = 1'b0;

    wlog_a.delete(); wlog_d.delete();
    run_mem(1'b1, 2'b01, 32'h40, 32'h1234_BEEF, 32'h0);
    check_val("st_wcount", 32'(wlog_a.size()), 32'd2);
    if (wlog_a.size() == 2) begin
      check_val("st_w0_addr", wlog_a[0], 32'h40);
      check_val("st_w0_data", {24'd0, wlog_d[0]}, 32'hEF);
      check_val("st_w1_addr", wlog_a[1], 32'h41);
      check_val("st_w1_data", {24'd0, wlog_d[1]}, 32'hBE);
    end
    check_val("st_42_untouched", {24'd0, ram[12'h042]}, 32'h33);
    run_mem(1'b0, 2'b01, 32'h40, 32'h0, 32'h0000_BEEF);
    run_mem(1'b0, 2'b11, 32'h41, 32'h0, 32'h5544_33BE);

    // Reset while byte 2 of a fetch is on the bus.
    @(negedge clk);
    if_req_i = 1'b1; if_addr_i = 32'h300;
    repeat (3) @(posedge clk);
    #1;
    check_val("rstmid_byte2_addr", ram_addr_o, 32'h302);
    rst = 1'b0;
    #1;
    check_val("rstmid_ram_wr", {31'd0, ram_wr_o}, 32'd0);
    check_val("rstmid_ram_addr", ram_addr_o, 32'h0);
    check_val("rstmid_if_done", {31'd0, if_done_o}, 32'd0);
    if_req_i = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check_val("rstmid_no_done", {31'd0, if_done_o}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    run_fetch(32'h0000_0300, 32'hEFBE_ADDE, 5);

    run_fetch(32'hFFFF_FFFE, 32'h0403_0201, 5);

    run_fetch(32'h0000_0200, 32'h1234_5678, 5);
`ifdef MEM_CTRL_FETCH_BUF_EN
    run_fetch(32'h0000_0200, 32'h1234_5678, 1);
`else
    run_fetch(32'h0000_0200, 32'h1234_5678, 5);
`endif
    run_mem(1'b1, 2'b00, 32'h80, 32'h0000_0099, 32'h0);
    run_fetch(32'h0000_0200, 32'h1234_5678, 5);

    repeat (3) @(posedge clk);
    #2;
    check_val("q_if_empty", 32'(q_if.size()), 32'd0);
    check_val("q_mem_empty", 32'(q_mem.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
